axi_rd_arbiter: RTL and testbench

//  Two-master to one-slave arbiter for the AXI-lite read channels (AR, R) in front of the shared instruction/data memory.

---
 rtl/axi_rd_arbiter.sv | 107 ++++++++++
 tb/tb_axi_rd_arbiter.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI-lite read arbiter (AR/R) with one outstanding read; grant held from AR select to R handshake.
// Build option: AXI_RD_ARB_RR_EN selects round-robin on simultaneous requests, otherwise LSU (m1) has fixed priority.
module axi_rd_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_arvalid,
   input  logic [ADDR_W-1:0] m0_araddr,
   output logic              m0_arready,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m0_rready,
   input  logic              m1_arvalid,
   input  logic [ADDR_W-1:0] m1_araddr,
   output logic              m1_arready,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   input  logic              m1_rready,
   output logic              s_arvalid,
   output logic [ADDR_W-1:0] s_araddr,
   input  logic              s_arready,
   input  logic              s_rvalid,
   input  logic [DATA_W-1:0] s_rdata,
   output logic              s_rready
);

   typedef enum logic [1:0] {
      IDLE,
      ADDR,
      DATA
   } state_t;

   state_t state;
   logic   grant;
   logic   last;
   logic   winner;
   logic   gnt_arvalid;
   logic   gnt_rready;
   logic   in_addr;
   logic   in_data;

   // With no request the winner is never registered; defaulting to last keeps it observable in both builds.
   always_comb begin
      winner = last;
      if (m0_arvalid && m1_arvalid) begin
`ifdef AXI_RD_ARB_RR_EN
         winner = ~last;
`else
         winner = 1'b1;
`endif
      end else if (m0_arvalid || m1_arvalid) begin
         winner = m1_arvalid;
      end
   end

   assign gnt_arvalid = grant ? m1_arvalid : m0_arvalid;
   assign gnt_rready  = grant ? m1_rready  : m0_rready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         grant <= 1'b0;
         last  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (m0_arvalid || m1_arvalid) begin
                  grant <= winner;
                  state <= ADDR;
               end
            end
            ADDR: begin
               // A granted master withdrawing its request before acceptance abandons the slot.
               if (gnt_arvalid && s_arready) begin
                  state <= DATA;
               end else if (!gnt_arvalid) begin
                  state <= IDLE;
               end
            end
            DATA: begin
               if (s_rvalid && gnt_rready) begin
                  last  <= grant;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign in_addr = (state == ADDR);
   assign in_data = (state == DATA);

   assign s_arvalid  = in_addr && gnt_arvalid;
   assign s_araddr   = grant ? m1_araddr : m0_araddr;
   assign m0_arready = in_addr && !grant && s_arready;
   assign m1_arready = in_addr &&  grant && s_arready;

   assign s_rready   = in_data && gnt_rready;
   assign m0_rvalid  = in_data && !grant && s_rvalid;
   assign m1_rvalid  = in_data &&  grant && s_rvalid;
   assign m0_rdata   = s_rdata;
   assign m1_rdata   = s_rdata;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus randomized masters/slave against a transaction-phase reference.
module tb_axi_rd_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam logic [31:0] KEY = 32'h5A5A_0F0F;
`ifdef AXI_RD_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          m0_arvalid, m0_arready, m0_rvalid, m0_rready;
   logic [AW-1:0] m0_araddr;
   logic [DW-1:0] m0_rdata;
   logic          m1_arvalid, m1_arready, m1_rvalid, m1_rready;
   logic [AW-1:0] m1_araddr;
   logic [DW-1:0] m1_rdata;
   logic          s_arvalid, s_arready, s_rvalid, s_rready;
   logic [AW-1:0] s_araddr;
   logic [DW-1:0] s_rdata;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   axi_rd_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst),
      .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
      .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rready(m0_rready),
      .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
      .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rready(m1_rready),
      .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
      .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rready(s_rready)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: which master owns the slot and whether it is waiting on AR acceptance or on R.
   typedef enum int {P_FREE, P_ADDR, P_RESP} phase_t;
   phase_t ph = P_FREE;
   bit     win = 1'b0;
   bit     last_m = 1'b1;

   function automatic bit arv(input bit m);
      return m ? m1_arvalid : m0_arvalid;
   endfunction

   function automatic bit rdy(input bit m);
      return m ? m1_rready : m0_rready;
   endfunction

   function automatic bit pick();
      if (m0_arvalid && m1_arvalid) return RR ? !last_m : 1'b1;
      return m1_arvalid;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ph     <= P_FREE;
         last_m <= 1'b1;
      end else begin
         case (ph)
            P_FREE: if (m0_arvalid || m1_arvalid) begin win <= pick(); ph <= P_ADDR; end
            P_ADDR: if (!arv(win)) ph <= P_FREE; else if (s_arready) ph <= P_RESP;
            P_RESP: if (s_rvalid && rdy(win)) begin ph <= P_FREE; last_m <= win; end
            default: ph <= P_FREE;
         endcase
      end
   end

   always @(negedge clk) begin
      case (ph)
         P_FREE: chk("idle_ctl", {s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready}, 6'b0);
         P_ADDR: begin
            chk("addr_ctl", {s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready},
                {arv(win), !win && s_arready, win && s_arready, 3'b000});
            chk("addr_mux", s_araddr, win ? m1_araddr : m0_araddr);
         end
         default: begin
            chk("data_ctl", {s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready},
                {3'b000, !win && s_rvalid, win && s_rvalid, rdy(win)});
            chk("data_mux", win ? m1_rdata : m0_rdata, s_rdata);
         end
      endcase
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic wait_sarvalid(input string tag, output int n);
      n = 0;
      smp();
      while (!s_arvalid && n < 20) begin
         cyc();
         smp();
         n++;
      end
      chk(tag, s_arvalid, 1'b1);
   endtask

   // Acts as the memory for one transaction and checks it is routed to the expected master.
   task automatic serve(input string tag, input int unsigned ar_wait, input logic [31:0] data,
                        input bit exp_who, input logic [31:0] exp_addr);
      int n;
      wait_sarvalid({tag, "_arv"}, n);
      repeat (ar_wait) cyc();
      cyc();
      s_arready = 1'b1;
      smp();
      chk({tag, "_arready"}, {m1_arready, m0_arready}, exp_who ? 2'b10 : 2'b01);
      chk({tag, "_addr"}, s_araddr, exp_addr);
      cyc();
      if (exp_who) m1_arvalid = 1'b0; else m0_arvalid = 1'b0;
      s_arready = 1'b0;
      s_rvalid  = 1'b1;
      s_rdata   = data;
      m0_rready = 1'b1;
      m1_rready = 1'b1;
      smp();
      chk({tag, "_rvalid"}, {m1_rvalid, m0_rvalid}, exp_who ? 2'b10 : 2'b01);
      chk({tag, "_rdata"}, exp_who ? m1_rdata : m0_rdata, data);
      cyc();
      s_rvalid  = 1'b0;
      m0_rready = 1'b0;
      m1_rready = 1'b0;
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      cyc();
   endtask

   bit            arv_d[2];
   bit            rdy_d[2];
   bit            wait_r[2];
   logic [31:0]   maddr[2];
   bit            arhs[2];
   bit            rhs[2];
   logic [31:0]   rd[2];
   bit            pend;
   logic [31:0]   paddr;
   int unsigned   dly;
   int            rx_cnt;

   initial begin
      int n;
      bit s_arhs, s_rhs;
      m0_arvalid = 0; m0_araddr = '0; m0_rready = 0;
      m1_arvalid = 0; m1_araddr = '0; m1_rready = 0;
      s_arready = 0; s_rvalid = 0; s_rdata = '0;
      rst = 1'b1;
      repeat (3) cyc();
      chk("reset_out", {s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready}, 6'b0);
      rst = 1'b0;
      cyc();

      // Single IFU read with delayed acceptance.
      m0_arvalid = 1'b1;
      m0_araddr  = 32'h8000_0000;
      wait_sarvalid("t1_arv", n);
      chk("t1_latency", n, 1);
      serve("t1", 2, 32'h0000_0013, 1'b0, 32'h8000_0000);

      // Simultaneous requests, twice.
      pulse_rst();
      for (int p = 0; p < 2; p++) begin
         m0_arvalid = 1'b1; m0_araddr = 32'h8000_0040;
         m1_arvalid = 1'b1; m1_araddr = 32'h8000_1000;
         serve("t2_first", 0, 32'h1111_0000 + p, RR ? 1'b0 : 1'b1, RR ? 32'h8000_0040 : 32'h8000_1000);
         wait_sarvalid("t2_bubble_arv", n);
         chk("t2_bubble", n, 1);
         serve("t2_second", 0, 32'h2222_0000 + p, RR ? 1'b1 : 1'b0, RR ? 32'h8000_1000 : 32'h8000_0040);
      end

      // Response back-pressure from the granted master.
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0200;
      wait_sarvalid("t3_arv", n);
      cyc(); s_arready = 1'b1;
      cyc(); m0_arvalid = 1'b0; s_arready = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hCAFE_F00D; m0_rready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         smp();
         chk("t3_stall", {s_rready, m0_rvalid}, 2'b01);
         chk("t3_rdata", m0_rdata, 32'hCAFE_F00D);
         cyc();
      end
      m0_rready = 1'b1;
      smp();
      chk("t3_release", s_rready, 1'b1);
      cyc(); s_rvalid = 1'b0; m0_rready = 1'b0;
      smp();
      chk("t3_done", m0_rvalid, 1'b0);

      // Reset while waiting for the response.
      cyc();
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0100;
      wait_sarvalid("t4_arv", n);
      cyc(); s_arready = 1'b1;
      cyc(); m0_arvalid = 1'b0; s_arready = 1'b0; m0_rready = 1'b1;
      smp();
      chk("t4_wait", m0_rvalid, 1'b0);
      cyc(); rst = 1'b1;
      #1;
      chk("t4_rst_out", {s_arvalid, m0_arready, m1_arready, m0_rvalid, m1_rvalid, s_rready}, 6'b0);
      cyc(); rst = 1'b0; s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF;
      smp();
      chk("t4_stale", {m0_rvalid, s_rready}, 2'b00);
      cyc(); s_rvalid = 1'b0; m0_rready = 1'b0;
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0300;
      serve("t4_next", 1, 32'h0000_1234, 1'b0, 32'h8000_0300);

      // Granted IFU withdraws before acceptance; pending LSU takes over.
      m0_arvalid = 1'b1; m0_araddr = 32'h8000_0400;
      wait_sarvalid("t5_arv", n);
      cyc(); m1_arvalid = 1'b1; m1_araddr = 32'h8000_1400;
      smp();
      chk("t5_hold", {m1_arready, s_araddr}, {1'b0, 32'h8000_0400});
      cyc(); m0_arvalid = 1'b0;
      smp();
      chk("t5_abort", s_arvalid, 1'b0);
      serve("t5_m1", 0, 32'h0000_5555, 1'b1, 32'h8000_1400);

      // Randomized traffic.
      pend = 0; rx_cnt = 0; dly = 0; paddr = '0;
      for (int m = 0; m < 2; m++) begin
         arv_d[m] = 0; rdy_d[m] = 0; wait_r[m] = 0; maddr[m] = '0;
      end
      for (int c = 0; c < 4000; c++) begin
         smp();
         arhs[0] = m0_arvalid && m0_arready; arhs[1] = m1_arvalid && m1_arready;
         rhs[0]  = m0_rvalid && m0_rready;   rhs[1]  = m1_rvalid && m1_rready;
         rd[0]   = m0_rdata;                 rd[1]   = m1_rdata;
         s_arhs  = s_arvalid && s_arready;
         s_rhs   = s_rvalid && s_rready;
         if (s_rhs) pend = 0;
         if (s_arhs) begin pend = 1; paddr = s_araddr; dly = $urandom_range(0, 3); end
         for (int m = 0; m < 2; m++) begin
            if (rhs[m]) begin
               chk("rnd_unexp_r", wait_r[m], 1'b1);
               chk("rnd_rdata", rd[m], maddr[m] ^ KEY);
               wait_r[m] = 0;
               rx_cnt++;
            end
         end
         cyc();
         for (int m = 0; m < 2; m++) begin
            if (arhs[m]) begin
               arv_d[m] = 0; wait_r[m] = 1;
            end else if (arv_d[m] && $urandom_range(0, 15) == 0) begin
               arv_d[m] = 0;
            end else if (!arv_d[m] && !wait_r[m] && $urandom_range(0, 3) == 0) begin
               arv_d[m] = 1; maddr[m] = $urandom;
            end
            rdy_d[m] = 1'($urandom_range(0, 1));
         end
         if (s_rhs) s_rvalid = 1'b0;
         if (pend && !s_rvalid) begin
            if (dly == 0) begin s_rvalid = 1'b1; s_rdata = paddr ^ KEY; end
            else dly--;
         end
         if (!s_rvalid) s_rdata = $urandom;
         s_arready  = 1'($urandom_range(0, 1));
         m0_arvalid = arv_d[0]; m0_araddr = maddr[0]; m0_rready = rdy_d[0];
         m1_arvalid = arv_d[1]; m1_araddr = maddr[1]; m1_rready = rdy_d[1];
      end
      chk("rnd_progress", rx_cnt > 100, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
